heading_pid: RTL and testbench

Closed-loop heading controller, directly downstream of the inertial interface. It consumes the fused heading and its valid strobe, compares the heading against the commanded heading, and runs a saturating PID. It produces signed left/right wheel speed commands for the motor-drive/PWM stage. All arithmetic is fixed-point and sign-extended explicitly; a two-stage output pipeline keeps timing off the multiplier path.

---
 rtl/heading_pid.sv | 85 ++++++++
 tb/tb_heading_pid.sv | 139 +++++++++++++
 2 files changed

// File: rtl/heading_pid.sv
// heading_pid: saturating fixed-point PID turning heading error into left/right wheel speeds.
// Two register stages (PID sum, then speed mix) keep the multiplier off the output path.
module heading_pid #(
    parameter bit         FAST_SIM    = 1'b1,
    parameter logic [3:0] P_COEFF     = 4'd5,
    parameter logic [9:0] AT_HDNG_TOL = 10'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        moving,
    input  logic        hdng_vld,
    input  logic [11:0] dsrd_hdng,
    input  logic [11:0] actl_hdng,
    input  logic [9:0]  frwrd,
    output logic [11:0] lft_spd,
    output logic [11:0] rght_spd,
    output logic        at_hdng
);
    logic signed [12:0] err;
    logic signed [9:0]  err_sat;
    logic signed [10:0] d_diff;
    logic [6:0]  d_sat;
    logic [13:0] p_term;
    logic [15:0] integ_q, integ_d, integ_sum;
    logic        ovf;
    logic [9:0]  prev1_q, prev1_d, prev2_q, prev2_d;
    logic [8:0]  d_term_q, d_term_d;
    logic [11:0] i_term, pid_s;
    logic [14:0] pid_q, pid_d;
    logic        mv1_q;
    logic [9:0]  frwrd1_q;
    logic [11:0] lft_q, lft_d, rght_q, rght_d;
    logic        at_q, at_d;

    always_comb begin
        err       = {actl_hdng[11], actl_hdng} - {dsrd_hdng[11], dsrd_hdng};
        err_sat   = (err > 13'sd511) ? 10'sd511 : (err < -13'sd512) ? -10'sd512 : err[9:0];
        p_term    = {{4{err_sat[9]}}, err_sat} * {10'd0, P_COEFF};
        at_d      = (err_sat < $signed(AT_HDNG_TOL)) && (err_sat > -$signed(AT_HDNG_TOL));
        // Overflow only when operands agree in sign and the sum flips it; hold instead of wrap
        integ_sum = integ_q + {{6{err_sat[9]}}, err_sat};
        ovf       = (integ_q[15] == err_sat[9]) && (integ_sum[15] != integ_q[15]);
        integ_d   = !moving ? '0 : (hdng_vld && !ovf) ? integ_sum : integ_q;
        d_diff    = {err_sat[9], err_sat} - {prev2_q[9], prev2_q};
        d_sat     = (d_diff > 11'sd63) ? 7'h3f : (d_diff < -11'sd64) ? 7'h40 : d_diff[6:0];
        d_term_d  = !moving ? '0 : hdng_vld ? {d_sat, 2'b00} : d_term_q;
        prev1_d   = !moving ? '0 : hdng_vld ? err_sat : prev1_q;
        prev2_d   = !moving ? '0 : hdng_vld ? prev1_q : prev2_q;
        i_term    = FAST_SIM ? integ_q[15:4] : {{2{integ_q[15]}}, integ_q[15:6]};
        pid_d     = {p_term[13], p_term} + {{3{i_term[11]}}, i_term} + {{6{d_term_q[8]}}, d_term_q};
        pid_s     = pid_q[14:3];
        lft_d     = mv1_q ? {2'b00, frwrd1_q} + pid_s : '0;
        rght_d    = mv1_q ? {2'b00, frwrd1_q} - pid_s : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q  <= '0;
            prev1_q  <= '0;
            prev2_q  <= '0;
            d_term_q <= '0;
            pid_q    <= '0;
            mv1_q    <= 1'b0;
            frwrd1_q <= '0;
            lft_q    <= '0;
            rght_q   <= '0;
            at_q     <= 1'b0;
        end else begin
            integ_q  <= integ_d;
            prev1_q  <= prev1_d;
            prev2_q  <= prev2_d;
            d_term_q <= d_term_d;
            pid_q    <= pid_d;
            mv1_q    <= moving;
            frwrd1_q <= frwrd;
            lft_q    <= lft_d;
            rght_q   <= rght_d;
            at_q     <= at_d;
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign at_hdng  = at_q;
endmodule

// File: tb/tb_heading_pid.sv
// tb_heading_pid: directed test-plan cases plus randomized traffic against an integer reference model.
module tb_heading_pid;
    logic        clk = 1'b0, rst_n = 1'b0, moving = 1'b0, hdng_vld = 1'b0;
    logic [11:0] dsrd_hdng = '0, actl_hdng = '0;
    logic [9:0]  frwrd = '0;
    logic [11:0] lft_spd, rght_spd;
    logic        at_hdng;
    int checks = 0, errors = 0;
    int m_int, m_p1, m_p2, m_d, m_pid, m_mv1, m_fw1, m_lft, m_rgt, m_at;

    heading_pid #(.FAST_SIM(1'b1), .P_COEFF(4'd5), .AT_HDNG_TOL(10'd10)) dut (
        .clk(clk), .rst_n(rst_n), .moving(moving), .hdng_vld(hdng_vld),
        .dsrd_hdng(dsrd_hdng), .actl_hdng(actl_hdng), .frwrd(frwrd),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .at_hdng(at_hdng)
    );

    always #5 clk = ~clk;

    function automatic int clamp(int v, int lo, int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic int wrap12(int v);
        int w = v & 4095;
        return w >= 2048 ? w - 4096 : w;
    endfunction

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_int, m_p1, m_p2, m_d, m_pid, m_mv1, m_fw1, m_lft, m_rgt, m_at} = '0;
    endtask

    // One clock edge of the spec's behaviour, using values in effect before the edge
    task automatic model_step();
        int es, i_t, s;
        es    = clamp(int'($signed(actl_hdng)) - int'($signed(dsrd_hdng)), -512, 511);
        i_t   = m_int >>> 4;
        m_lft = m_mv1 ? wrap12(m_fw1 + (m_pid >>> 3)) : 0;
        m_rgt = m_mv1 ? wrap12(m_fw1 - (m_pid >>> 3)) : 0;
        m_pid = es * 5 + i_t + m_d;
        m_mv1 = int'(moving);
        m_fw1 = int'(frwrd);
        m_at  = (es < 10 && es > -10) ? 1 : 0;
        if (!moving) begin
            m_int = 0; m_p1 = 0; m_p2 = 0; m_d = 0;
        end else if (hdng_vld) begin
            s = m_int + es;
            if (s >= -32768 && s <= 32767) m_int = s;
            m_d  = clamp(es - m_p2, -64, 63) * 4;
            m_p2 = m_p1;
            m_p1 = es;
        end
    endtask

    task automatic cyc(input logic mv, input logic vld, input logic [11:0] d, input logic [11:0] a,
                       input logic [9:0] f);
        moving = mv; hdng_vld = vld; dsrd_hdng = d; actl_hdng = a; frwrd = f;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("lft_spd", int'($signed(lft_spd)), m_lft);
        check("rght_spd", int'($signed(rght_spd)), m_rgt);
        check("at_hdng", int'(at_hdng), m_at);
    endtask

    task automatic settle(input logic [11:0] d, input logic [11:0] a, input logic [9:0] f);
        repeat (3) cyc(1'b1, 1'b0, d, a, f);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_at", int'(at_hdng), 0);
        @(negedge clk);
        rst_n = 1'b1;

        settle(12'd0, 12'd0, 10'd256);
        check("zero_lft", int'($signed(lft_spd)), 256);
        check("zero_rght", int'($signed(rght_spd)), 256);
        check("zero_at", int'(at_hdng), 1);

        settle(12'd0, 12'd40, 10'd256);
        check("p40_lft", int'($signed(lft_spd)), 281);
        check("p40_rght", int'($signed(rght_spd)), 231);
        check("p40_at", int'(at_hdng), 0);

        settle(12'h800, 12'h7ff, 10'd256);
        check("sat_lft", int'($signed(lft_spd)), 575);
        check("sat_rght", int'(rght_spd), 12'hfc1);

        repeat (2) cyc(1'b0, 1'b0, 12'd0, 12'd16, 10'd256);
        repeat (10) cyc(1'b1, 1'b1, 12'd0, 12'd16, 10'd256);
        settle(12'd0, 12'd16, 10'd256);
        check("i16_lft", int'($signed(lft_spd)), 267);
        check("i16_rght", int'($signed(rght_spd)), 245);

        repeat (2) cyc(1'b0, 1'b0, 12'd0, 12'd511, 10'd256);
        repeat (100) cyc(1'b1, 1'b1, 12'd0, 12'd511, 10'd256);
        settle(12'd0, 12'd511, 10'd256);
        check("isat_lft", int'($signed(lft_spd)), 830);
        check("isat_rght", int'($signed(rght_spd)), -318);

        cyc(1'b0, 1'b1, 12'd0, 12'd511, 10'd256);
        repeat (2) cyc(1'b0, 1'b0, 12'd0, 12'd511, 10'd256);
        check("stop_lft", int'(lft_spd), 0);
        check("stop_rght", int'(rght_spd), 0);
        settle(12'd0, 12'd0, 10'd256);
        check("restart_lft", int'($signed(lft_spd)), 256);

        for (int i = 0; i < 400; i++) begin
            logic [11:0] d, a;
            d = 12'($urandom);
            a = ($urandom % 2) ? 12'($urandom) : d + 12'($urandom_range(0, 30)) - 12'd15;
            cyc(($urandom % 8) != 0, 1'($urandom), d, a, 10'($urandom));
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1;
                check("arst_lft", int'(lft_spd), 0);
                check("arst_rght", int'(rght_spd), 0);
                check("arst_at", int'(at_hdng), 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
